// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: request/ack bundle of the fetch and memory stages plus the RAM bus.
// master = requesters and RAM side, slave = the arbiter.
interface ram_arbiter_if;
   logic        i_req;
   logic [31:0] i_addr;
   logic        i_ack;
   logic [31:0] i_rdata;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_ack;
   logic [31:0] d_rdata;
   logic [31:0] ram_address;
   logic [31:0] ram_data_in;
   logic        ram_write_enable;
   logic [31:0] ram_data_out;
   logic        busy;
   logic        owner;

   modport master (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata, ram_data_out,
      input  i_ack, i_rdata, d_ack, d_rdata, ram_address, ram_data_in, ram_write_enable, busy, owner
   );

   modport slave (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, ram_data_out,
      output i_ack, i_rdata, d_ack, d_rdata, ram_address, ram_data_in, ram_write_enable, busy, owner
   );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares the single-ported RAM between instruction fetch and the data port.
// Data has priority; a starve counter forces an instruction grant after STARVE_LIMIT data wins.
module ram_arbiter #(
   parameter int RAM_LATENCY  = 1,
   parameter int STARVE_LIMIT = 4
) (
   input logic          clk,
   input logic          rst,
   ram_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
   state_t     state;
   logic [3:0] cnt;
   logic [3:0] starve;
   logic       is_write;
   logic       grant_i;

   always_comb grant_i = bus.i_req && (!bus.d_req || starve == 4'(STARVE_LIMIT));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state                <= IDLE;
         cnt                  <= '0;
         starve               <= '0;
         is_write             <= 1'b0;
         bus.i_ack            <= 1'b0;
         bus.d_ack            <= 1'b0;
         bus.i_rdata          <= '0;
         bus.d_rdata          <= '0;
         bus.ram_address      <= '0;
         bus.ram_data_in      <= '0;
         bus.ram_write_enable <= 1'b0;
         bus.busy             <= 1'b0;
         bus.owner            <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               // a data win while instruction waits cannot happen at the limit, so +1 never overflows it
               starve <= (bus.i_req && !grant_i) ? starve + 4'd1 : '0;
               if (bus.i_req || bus.d_req) begin
                  bus.ram_address      <= grant_i ? bus.i_addr : bus.d_addr;
                  if (!grant_i) bus.ram_data_in <= bus.d_wdata;
                  bus.ram_write_enable <= !grant_i && bus.d_we;
                  is_write             <= !grant_i && bus.d_we;
                  bus.owner            <= !grant_i;
                  bus.busy             <= 1'b1;
                  cnt                  <= 4'(RAM_LATENCY - 1);
                  state                <= ACCESS;
               end
            end
            ACCESS: begin
               bus.ram_write_enable <= 1'b0;
               cnt                  <= cnt - 4'd1;
               if (cnt == 4'd0) begin
                  if (!is_write && bus.owner)  bus.d_rdata <= bus.ram_data_out;
                  if (!is_write && !bus.owner) bus.i_rdata <= bus.ram_data_out;
                  bus.i_ack <= !bus.owner;
                  bus.d_ack <= bus.owner;
                  state     <= DONE;
               end
            end
            DONE: begin
               bus.i_ack <= 1'b0;
               bus.d_ack <= 1'b0;
               bus.busy  <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: two arbiters (latency 1 / starve 2 and latency 3 / starve 4) on behavioural RAMs,
// checked against a reference memory and a grant-order model derived from the arbitration rules.
module tb_ram_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ram_arbiter_if ifa ();
   ram_arbiter_if ifb ();
   ram_arbiter #(.RAM_LATENCY(1), .STARVE_LIMIT(2)) u_a (.clk(clk), .rst(rst), .bus(ifa));
   ram_arbiter #(.RAM_LATENCY(3), .STARVE_LIMIT(4)) u_b (.clk(clk), .rst(rst), .bus(ifb));

   int n_chk = 0;
   int n_fail = 0;
   logic        sel = 1'b0;
   logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
   logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
   logic        i_ack, d_ack, busy, owner, we;
   logic [31:0] i_rdata, d_rdata, ram_addr;

   assign ifa.i_req   = i_req & ~sel;
   assign ifb.i_req   = i_req & sel;
   assign ifa.d_req   = d_req & ~sel;
   assign ifb.d_req   = d_req & sel;
   assign ifa.i_addr  = i_addr;
   assign ifb.i_addr  = i_addr;
   assign ifa.d_addr  = d_addr;
   assign ifb.d_addr  = d_addr;
   assign ifa.d_we    = d_we;
   assign ifb.d_we    = d_we;
   assign ifa.d_wdata = d_wdata;
   assign ifb.d_wdata = d_wdata;
   assign i_ack    = sel ? ifb.i_ack : ifa.i_ack;
   assign d_ack    = sel ? ifb.d_ack : ifa.d_ack;
   assign busy     = sel ? ifb.busy : ifa.busy;
   assign owner    = sel ? ifb.owner : ifa.owner;
   assign we       = sel ? ifb.ram_write_enable : ifa.ram_write_enable;
   assign i_rdata  = sel ? ifb.i_rdata : ifa.i_rdata;
   assign d_rdata  = sel ? ifb.d_rdata : ifa.d_rdata;
   assign ram_addr = sel ? ifb.ram_address : ifa.ram_address;

   // RAM models: combinational read for latency 1, two-stage read pipeline for latency 3
   logic [31:0] mem [256];
   logic [31:0] ref_mem [256];
   logic [31:0] pipe1, pipe2;
   logic [31:0] seed;
   logic        preload = 1'b1;

   function automatic logic [31:0] init_word(input int k);
      return (k == 4) ? 32'hDEADBEEF : (32'(k) * 32'h9E3779B9) ^ seed;
   endfunction

   assign ifa.ram_data_out = mem[ifa.ram_address[9:2]];
   assign ifb.ram_data_out = pipe2;
   always @(posedge clk) begin
      pipe1 <= mem[ifb.ram_address[9:2]];
      pipe2 <= pipe1;
      if (preload) for (int k = 0; k < 256; k++) mem[k] <= init_word(k);
      else begin
         if (ifa.ram_write_enable) mem[ifa.ram_address[9:2]] <= ifa.ram_data_in;
         if (ifb.ram_write_enable) mem[ifb.ram_address[9:2]] <= ifb.ram_data_in;
      end
   end

   function automatic logic [31:0] rand_addr();
      return 32'($urandom_range(0, 255)) << 2;
   endfunction

   // Drives one transaction from IDLE and reports what was observed; callers judge it.
   task automatic do_txn(input logic port_d, input logic we_in, input logic [31:0] addr, input logic [31:0] wdata,
                         output int ack_cyc, output int we_cyc, output int busy_cyc,
                         output logic [31:0] rdata, output logic other_ack, output logic [31:0] addr_c1);
      ack_cyc = -1; we_cyc = 0; busy_cyc = 0; other_ack = 1'b0; rdata = '0; addr_c1 = '0;
      if (port_d) begin d_req = 1'b1; d_we = we_in; d_addr = addr; d_wdata = wdata; end
      else begin i_req = 1'b1; i_addr = addr; end
      for (int k = 1; k <= 20 && ack_cyc < 0; k++) begin
         @(posedge clk); #1;
         if (k == 1) addr_c1 = ram_addr;
         we_cyc += int'(we);
         busy_cyc += int'(busy);
         other_ack |= port_d ? i_ack : d_ack;
         if (port_d ? d_ack : i_ack) begin ack_cyc = k; rdata = port_d ? d_rdata : i_rdata; end
      end
      i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      seed = $urandom;
      for (int k = 0; k < 256; k++) ref_mem[k] = init_word(k);
      repeat (2) @(posedge clk);
      #1 preload = 1'b0;
      for (int s = 0; s < 2; s++) begin
         sel = 1'(s); #1;
         n_chk++;
         if ({i_ack, d_ack, busy, owner, we} !== 5'b0) begin
            n_fail++; $display("FAIL reset_ctrl dut%0d: got %b want 00000", s, {i_ack, d_ack, busy, owner, we});
         end
         n_chk++;
         if ({ram_addr, i_rdata, d_rdata} !== 96'b0) begin
            n_fail++; $display("FAIL reset_data dut%0d: got %h want 0", s, {ram_addr, i_rdata, d_rdata});
         end
      end
      sel = 1'b0;
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_single_read();
      int ac, wc, bc; logic [31:0] rd, a1; logic oa;
      sel = 1'b0;
      do_txn(1'b0, 1'b0, 32'h10, 32'h0, ac, wc, bc, rd, oa, a1);
      n_chk++; if (a1 !== 32'h10) begin n_fail++; $display("FAIL read_addr: got %h want 00000010", a1); end
      n_chk++; if (ac !== 2) begin n_fail++; $display("FAIL read_ack_cycle: got %0d want 2", ac); end
      n_chk++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL read_data: got %h want deadbeef", rd); end
      n_chk++; if (bc !== 2 || wc !== 0 || oa !== 1'b0) begin
         n_fail++; $display("FAIL read_busy_we_dack: got busy=%0d we=%0d dack=%b want 2 0 0", bc, wc, oa);
      end
   endtask

   task automatic test_write_read();
      int ac, wc, bc; logic [31:0] rd, a1; logic oa;
      sel = 1'b0;
      do_txn(1'b1, 1'b1, 32'h20, 32'h12345678, ac, wc, bc, rd, oa, a1);
      ref_mem[8] = 32'h12345678;
      n_chk++; if (wc !== 1) begin n_fail++; $display("FAIL write_we_cycles: got %0d want 1", wc); end
      n_chk++; if (ac !== 2) begin n_fail++; $display("FAIL write_ack_cycle: got %0d want 2", ac); end
      n_chk++; if (rd !== 32'h0) begin n_fail++; $display("FAIL write_rdata_held: got %h want 0", rd); end
      do_txn(1'b1, 1'b0, 32'h20, 32'h0, ac, wc, bc, rd, oa, a1);
      n_chk++; if (rd !== 32'h12345678 || ac !== 2) begin
         n_fail++; $display("FAIL write_readback: got %h@%0d want 12345678@2", rd, ac);
      end
   endtask

   task automatic test_simultaneous();
      int dk = -1, ik = -1; logic d_own = 1'b0, i_own = 1'b1; logic [31:0] dv = '0, iv = '0, ai, ad;
      sel = 1'b0; ai = rand_addr(); ad = rand_addr();
      i_req = 1'b1; i_addr = ai; d_req = 1'b1; d_we = 1'b0; d_addr = ad;
      for (int k = 1; k <= 20 && ik < 0; k++) begin
         @(posedge clk); #1;
         if (d_ack) begin dk = k; d_own = owner; dv = d_rdata; d_req = 1'b0; end
         if (i_ack) begin ik = k; i_own = owner; iv = i_rdata; i_req = 1'b0; end
      end
      @(posedge clk); #1;
      n_chk++; if (dk !== 2 || d_own !== 1'b1) begin n_fail++; $display("FAIL simul_data_first: got cyc=%0d owner=%b want 2 1", dk, d_own); end
      n_chk++; if (ik !== 5 || i_own !== 1'b0) begin n_fail++; $display("FAIL simul_instr_next: got cyc=%0d owner=%b want 5 0", ik, i_own); end
      n_chk++; if (dv !== ref_mem[ad[9:2]] || iv !== ref_mem[ai[9:2]]) begin
         n_fail++; $display("FAIL simul_data: got %h %h want %h %h", dv, iv, ref_mem[ad[9:2]], ref_mem[ai[9:2]]);
      end
   endtask

   // Model: with instruction always waiting, data wins unless it has already won twice in a row.
   task automatic test_starvation();
      int streak = 0, grants = 0, wait_c = 0; logic idle = 1'b1; logic e; logic exp_q[$];
      sel = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
      rst = 1'b1; @(posedge clk); #1 rst = 1'b0;
      i_addr = rand_addr(); d_addr = rand_addr();
      for (int cyc = 0; cyc < 400 && grants < 12; cyc++) begin
         if (idle) begin
            i_req = 1'b1;
            if (!d_req) d_req = (grants < 6) ? 1'b1 : 1'($urandom_range(0, 1));
            if (d_req && streak != 2) begin exp_q.push_back(1'b1); streak++; end
            else begin exp_q.push_back(1'b0); streak = 0; end
            idle = 1'b0; wait_c = 0;
         end
         @(posedge clk); #1; wait_c++;
         if (i_ack || d_ack) begin
            e = exp_q.pop_front();
            grants++;
            n_chk++;
            if ({i_ack, d_ack, owner} !== {~e, e, e}) begin
               n_fail++; $display("FAIL starve_grant%0d: got i_ack=%b d_ack=%b owner=%b want owner=%b", grants, i_ack, d_ack, owner, e);
            end
            if (i_ack) begin
               n_chk++;
               if (i_rdata !== ref_mem[i_addr[9:2]]) begin n_fail++; $display("FAIL starve_idata: got %h want %h", i_rdata, ref_mem[i_addr[9:2]]); end
            end
            if (d_ack) d_req = 1'b0; else i_req = 1'b0;
            @(posedge clk); #1; idle = 1'b1;
         end else if (wait_c > 4) begin
            n_fail++; $display("FAIL starve_timeout: got no ack after %0d cycles want ack by 2", wait_c);
            break;
         end
      end
      i_req = 1'b0; d_req = 1'b0;
      @(posedge clk); #1;
      n_chk++; if (grants !== 12) begin n_fail++; $display("FAIL starve_count: got %0d want 12", grants); end
   endtask

   task automatic test_latency_sweep();
      int ac, wc, bc; logic [31:0] rd, a1, addr, wd, exp_d = '0; logic oa, pd, w;
      sel = 1'b1;
      for (int n = 0; n < 16; n++) begin
         pd = 1'($urandom_range(0, 1)); w = pd & 1'($urandom_range(0, 1));
         addr = rand_addr(); wd = $urandom;
         do_txn(pd, w, addr, wd, ac, wc, bc, rd, oa, a1);
         n_chk++;
         if (ac !== 4 || bc !== 4 || wc !== int'(w) || oa !== 1'b0 || a1 !== addr) begin
            n_fail++; $display("FAIL sweep%0d_timing: got ack=%0d busy=%0d we=%0d other=%b addr=%h want 4 4 %0d 0 %h", n, ac, bc, wc, oa, a1, w, addr);
         end
         n_chk++;
         if (rd !== (w ? exp_d : ref_mem[addr[9:2]])) begin
            n_fail++; $display("FAIL sweep%0d_data: got %h want %h", n, rd, w ? exp_d : ref_mem[addr[9:2]]);
         end
         if (w) ref_mem[addr[9:2]] = wd;
         else if (pd) exp_d = ref_mem[addr[9:2]];
      end
   endtask

   task automatic test_reset_mid_write();
      int ac, wc, bc; logic [31:0] rd, a1, addr; logic oa;
      sel = 1'b1; addr = rand_addr();
      d_req = 1'b1; d_we = 1'b1; d_addr = addr; d_wdata = ~ref_mem[addr[9:2]];
      @(posedge clk); #1;
      n_chk++; if ({we, busy} !== 2'b11) begin n_fail++; $display("FAIL rstw_access: got we,busy=%b want 11", {we, busy}); end
      #2 rst = 1'b1;
      #1;
      n_chk++;
      if ({we, i_ack, d_ack, busy, owner} !== 5'b0) begin
         n_fail++; $display("FAIL rstw_async: got %b want 00000", {we, i_ack, d_ack, busy, owner});
      end
      d_req = 1'b0; d_we = 1'b0;
      @(posedge clk); #1 rst = 1'b0;
      @(posedge clk); #1;
      n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstw_idle: got busy=%b want 0", busy); end
      do_txn(1'b0, 1'b0, addr, 32'h0, ac, wc, bc, rd, oa, a1);
      n_chk++;
      if (ac !== 4 || rd !== ref_mem[addr[9:2]]) begin
         n_fail++; $display("FAIL rstw_no_write: got %h@%0d want %h@4", rd, ac, ref_mem[addr[9:2]]);
      end
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_write_read();
      test_simultaneous();
      test_starvation();
      test_latency_sweep();
      test_reset_mid_write();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test by 200000 want earlier finish");
      $fatal(1);
   end
endmodule
